// File: rtl/rx_chan_scheduler_pkg.sv
// Shared definitions for the RX channel scheduler: FSM state encoding,
// default packet geometry and a small pointer-wrap helper.
package rx_sched_pkg;

  // FSM state encoding (2 bits)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Default packet geometry
  localparam int DEF_HDR_WORDS     = 4;
  localparam int DEF_PAYLOAD_WORDS = 252;

  // Reduce a round-robin pointer (0..8) modulo n (1..8) without a divider.
  // n == 0 returns the pointer unchanged; callers never use it in that case.
  function automatic logic [3:0] wrap_ptr(input logic [3:0] ptr, input logic [3:0] n);
    logic [3:0] r;
    r = ptr;
    for (int i = 0; i < 8; i++) begin
      if (n != 4'd0 && r >= n) r = r - n;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_chan_scheduler_if.sv
// Bus between the packet-writer environment and the RX channel scheduler.
// Handshake: a FIFO i "offers" a packet when chan_ready[i] is high and the
// sink "accepts" when have_space is high; a grant happens only in IDLE when
// both hold for an eligible FIFO, and once granted the packet always runs to
// completion (the offer/accept pair is an admission check, not a per-word
// handshake). fsm_state exposes the scheduler FSM for observation.
interface rx_chan_scheduler_if #(parameter int NUM_CHAN = 1);
  logic [3:0]        nchan;
  logic [NUM_CHAN:0] chan_ready;
  logic              have_space;
  logic [3:0]        rd_select;
  logic              chan_rdreq;
  logic              hdr_phase;
  logic              pkt_start;
  logic              pkt_done;
  logic [15:0]       grant_count;
  logic [1:0]        fsm_state;

  modport master (
    output nchan, chan_ready, have_space,
    input  rd_select, chan_rdreq, hdr_phase, pkt_start, pkt_done, grant_count, fsm_state
  );

  modport slave (
    input  nchan, chan_ready, have_space,
    output rd_select, chan_rdreq, hdr_phase, pkt_start, pkt_done, grant_count, fsm_state
  );
endinterface

// File: rtl/rx_chan_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after start,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 1
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   start,
  output logic [3:0]   idx,
  output logic         valid
);

  logic [15:0] req_ext;
  logic [4:0]  c;

  assign req_ext = 16'(req);

  // Scan N positions starting at 'start'; the first hit wins.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    c     = 5'd0;
    for (int k = 0; k < N; k++) begin
      c = {1'b0, start} + 5'(k);
      if (c >= 5'(N)) c = c - 5'(N);
      if (!valid && req_ext[c[3:0]]) begin
        valid = 1'b1;
        idx   = c[3:0];
      end
    end
  end

endmodule

// File: rtl/rx_chan_scheduler.sv
// RX channel scheduler: grants one FIFO per packet (command FIFO first, data
// FIFOs round-robin), then sequences header, payload burst and a gap cycle.
// Optional macro RX_SCHED_STATS_EN adds a saturating packet-grant counter.
module rx_chan_scheduler
  import rx_sched_pkg::*;
#(
  parameter int NUM_CHAN      = 1,
  parameter int HDR_WORDS     = DEF_HDR_WORDS,
  parameter int PAYLOAD_WORDS = DEF_PAYLOAD_WORDS
) (
  input  logic rxclk,
  input  logic reset,
  rx_chan_scheduler_if.slave bus
);

  logic [1:0]          state;
  logic [8:0]          cnt;
  logic [3:0]          sel;
  logic [3:0]          rr_ptr;     // last data grant + 1, reduced at use
  logic [3:0]          nclamp;
  logic [3:0]          start;
  logic [NUM_CHAN-1:0] data_mask;
  logic [3:0]          pick_idx;
  logic                pick_valid;
  logic                cmd_req;
  logic                grant;

  assign nclamp  = (bus.nchan > 4'(NUM_CHAN)) ? 4'(NUM_CHAN) : bus.nchan;
  assign start   = wrap_ptr(rr_ptr, nclamp);
  assign cmd_req = bus.chan_ready[NUM_CHAN];
  assign grant   = bus.have_space && (cmd_req || pick_valid);

  // Only data channels below the clamped channel count may request.
  always_comb begin
    data_mask = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      data_mask[i] = bus.chan_ready[i] && (4'(i) < nclamp);
    end
  end

  rr_pick #(.N(NUM_CHAN)) u_pick (
    .req   (data_mask),
    .start (start),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Packet FSM; one down-counter serves both header and burst phases.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 9'd0;
      sel    <= 4'd0;
      rr_ptr <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= ST_HDR;
            cnt   <= 9'(HDR_WORDS - 1);
            if (cmd_req) begin
              sel <= 4'(NUM_CHAN);
            end else begin
              sel    <= pick_idx;
              rr_ptr <= pick_idx + 4'd1;
            end
          end
        end
        ST_HDR: begin
          if (cnt == 9'd0) begin
            state <= ST_BURST;
            cnt   <= 9'(PAYLOAD_WORDS - 1);
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        ST_BURST: begin
          if (cnt == 9'd0) state <= ST_GAP;
          else             cnt   <= cnt - 9'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_select  = sel;
  assign bus.chan_rdreq = (state == ST_BURST);
  assign bus.hdr_phase  = (state == ST_HDR);
  assign bus.pkt_start  = (state == ST_HDR) && (cnt == 9'(HDR_WORDS - 1));
  assign bus.pkt_done   = (state == ST_GAP);
  assign bus.fsm_state  = state;

`ifdef RX_SCHED_STATS_EN
  logic [15:0] grant_q;

  // Count packets started, saturating at all-ones.
  always_ff @(posedge rxclk) begin
    if (reset)                                  grant_q <= 16'd0;
    else if (bus.pkt_start && grant_q != 16'hFFFF) grant_q <= grant_q + 16'd1;
  end

  assign bus.grant_count = grant_q;
`else
  assign bus.grant_count = 16'd0;
`endif

endmodule

// File: tb/tb_rx_chan_scheduler.sv
// Testbench for rx_chan_scheduler (NUM_CHAN=2): directed and randomized
// packets checked against a transaction-level scheduling model.
module tb_rx_chan_scheduler;
  localparam int NC = 2;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   last_data;
  int   gc_model;

  rx_chan_scheduler_if #(.NUM_CHAN(NC)) bus ();

  rx_chan_scheduler #(.NUM_CHAN(NC)) dut (
    .rxclk (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Returns granted FIFO index, or -1 when nothing may be granted.
  function automatic int model_pick(input logic [NC:0] rdy, input int nch, input bit space);
    int nc;
    int st;
    int c;
    if (!space) return -1;
    if (rdy[NC]) return NC;
    nc = (nch > NC) ? NC : nch;
    if (nc == 0) return -1;
    st = (last_data + 1) % nc;
    for (int k = 0; k < nc; k++) begin
      c = (st + k) % nc;
      if (rdy[c]) return c;
    end
    return -1;
  endfunction

  function automatic int gc_expected();
`ifdef RX_SCHED_STATS_EN
    return gc_model;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NC:0] rdy, input int nch, input bit space);
    bus.chan_ready = rdy;
    bus.nchan      = 4'(nch);
    bus.have_space = space;
  endtask

  // Inputs are already applied at this negedge; follow one whole packet.
  task automatic run_packet(input int exp_sel, input bit scramble);
    int lat;
    int hdr;
    int rd;
    int starts;
    int sel_bad;
    int done_at;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.pkt_start) break;
    end
    check("start_latency", lat, 1);
    if (!bus.pkt_start) return;
    check("rd_select", bus.rd_select, exp_sel);
    hdr = 1; rd = 0; starts = 1; sel_bad = 0; done_at = 0;
    for (int t = 1; t < 300; t++) begin
      @(negedge clk);
      if (scramble) drive(3'($urandom_range(0, 7)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      if (bus.hdr_phase)  hdr++;
      if (bus.chan_rdreq) rd++;
      if (bus.pkt_start)  starts++;
      if (bus.rd_select != 4'(exp_sel)) sel_bad++;
      if (bus.pkt_done) begin
        done_at = t;
        break;
      end
    end
    check("hdr_cycles", hdr, 4);
    check("rdreq_cycles", rd, 252);
    check("start_pulses", starts, 1);
    check("sel_stable", sel_bad, 0);
    check("done_offset", done_at, 256);
    if (exp_sel < NC) last_data = exp_sel;
    if (gc_model < 65535) gc_model++;
    @(negedge clk);
    check("idle_strobes", {bus.pkt_start, bus.hdr_phase, bus.chan_rdreq, bus.pkt_done}, 0);
    check("grant_count", bus.grant_count, gc_expected());
  endtask

  // Apply inputs and either expect a packet or expect the FSM to stay idle.
  task automatic apply(input logic [NC:0] rdy, input int nch, input bit space, input bit scramble);
    int exp_sel;
    int bad;
    drive(rdy, nch, space);
    exp_sel = model_pick(rdy, nch, space);
    if (exp_sel >= 0) begin
      run_packet(exp_sel, scramble);
    end else begin
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.pkt_start || bus.hdr_phase || bus.chan_rdreq || bus.pkt_done) bad++;
      end
      check("stay_idle", bad, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd;
    int bad;
    int lat;
    total = 0; passed = 0; last_data = -1; gc_model = 0;
    rst = 1'b1;
    drive(3'b000, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_sel", bus.rd_select, 0);
    check("reset_strobes", {bus.pkt_start, bus.hdr_phase, bus.chan_rdreq, bus.pkt_done}, 0);
    check("reset_state", bus.fsm_state, 0);
    check("reset_gc", bus.grant_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // single data packet on channel 0
    apply(3'b001, 2, 1'b1, 1'b0);
    // alternating data channels
    repeat (4) apply(3'b011, 2, 1'b1, 1'b0);
    // command FIFO dominates
    repeat (3) apply(3'b111, 2, 1'b1, 1'b0);

    // no space for 100 cycles
    drive(3'b001, 2, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.pkt_start || bus.hdr_phase || bus.chan_rdreq) bad++;
    end
    check("no_space_idle", bad, 0);
    apply(3'b001, 2, 1'b1, 1'b0);

    // nchan=0 serves only command; nchan above NUM_CHAN is clamped
    apply(3'b011, 0, 1'b1, 1'b0);
    apply(3'b111, 0, 1'b1, 1'b0);
    repeat (2) apply(3'b011, 15, 1'b1, 1'b0);
    apply(3'b000, 2, 1'b1, 1'b0);

    // randomized packets with input disturbance during the packet
    for (int i = 0; i < 25; i++) begin
      apply(3'($urandom_range(0, 7)), $urandom_range(0, 15), ($urandom_range(0, 3) != 0), 1'b1);
    end

    // reset mid-burst at payload word 100
    drive(3'b011, 2, 1'b1);
    lat = 0;
    while (lat < 10 && !bus.pkt_start) begin
      @(negedge clk);
      lat++;
    end
    check("rst_test_start", bus.pkt_start, 1);
    rd = 0;
    for (int i = 0; i < 400 && rd < 100; i++) begin
      @(negedge clk);
      if (bus.chan_rdreq) rd++;
    end
    check("rst_test_words", rd, 100);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdreq", bus.chan_rdreq, 0);
    check("rst_done", bus.pkt_done, 0);
    check("rst_gc", bus.grant_count, 0);
    check("rst_sel", bus.rd_select, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.pkt_done || bus.chan_rdreq || bus.hdr_phase) bad++;
    end
    check("rst_quiet", bad, 0);
    rst = 1'b0;
    last_data = -1;
    gc_model = 0;
    apply(3'b011, 2, 1'b1, 1'b0);
    repeat (2) apply(3'b011, 2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
